xf100_ifu: RTL

XF100_IFU -- requirements
Module: xf100_ifu

---
 rtl/xf100_ifu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/xf100_ifu.sv
// ---------------------------------------------------------------------------
// xf100_ifu -- instruction fetch unit for the XF100 core
//
// Purpose:
//   Fetches 32-bit instructions from a synchronous instruction RAM that
//   returns data one cycle after its read strobe. Returned words are held
//   with their PCs in a 2-entry FIFO that feeds the execute stage over a
//   valid/ready handshake. A downstream redirect flushes everything in
//   flight and restarts fetch at the new target.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   IRAM_AW   instruction RAM word-address width
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   ifu_o_ram_cs     instruction RAM read strobe
//   ifu_o_ram_addr   RAM word address (fetch_pc[IRAM_AW+1:2])
//   ifu_i_ram_rdat   RAM read data, valid one cycle after the strobe
//   ifu_o_valid      instruction available at the buffer head
//   ifu_i_ready      execute stage accepts the head instruction this cycle
//   ifu_o_instr      head instruction
//   ifu_o_pc         PC of the head instruction
//   ifu_i_redir_en   redirect request (branch/jump)
//   ifu_i_redir_pc   redirect target
//   ifu_o_misalign   sticky misaligned-redirect flag (optional, see below)
//
// Configuration:
//   XF100_IFU_MISALIGN_CHK_EN  when defined, a redirect to a target with
//   nonzero low bits flushes, raises ifu_o_misalign and halts fetch until
//   reset or an aligned redirect. When undefined, the port is absent and
//   the target's low two bits are ignored.
// ---------------------------------------------------------------------------
module xf100_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IRAM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_o_ram_cs,
  output logic [IRAM_AW-1:0] ifu_o_ram_addr,
  input  logic [31:0]        ifu_i_ram_rdat,
  output logic               ifu_o_valid,
  input  logic               ifu_i_ready,
  output logic [31:0]        ifu_o_instr,
  output logic [31:0]        ifu_o_pc,
  input  logic               ifu_i_redir_en,
  input  logic [31:0]        ifu_i_redir_pc
`ifdef XF100_IFU_MISALIGN_CHK_EN
  ,
  output logic               ifu_o_misalign
`endif
);

  // Fetch state
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic        inflight_q,    inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  // Instruction buffer: 2 entries addressed by 1-bit read/write pointers
  logic [31:0] ent_pc_q    [2];
  logic [31:0] ent_pc_d    [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q,  count_d;

`ifdef XF100_IFU_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
  logic        redir_bad;
`else
  logic        redir_lsb_unused;
`endif

  logic [31:0] redir_pc_eff;
  logic        fetch_halt;
  logic        push;
  logic        pop;
  logic [2:0]  demand;
  logic [2:0]  room;

  // Effective redirect target and the fetch-halt condition. Without the
  // misalignment checker the low target bits are simply discarded.
`ifdef XF100_IFU_MISALIGN_CHK_EN
  assign redir_pc_eff = ifu_i_redir_pc;
  assign redir_bad    = |ifu_i_redir_pc[1:0];
  assign fetch_halt   = misalign_q;
`else
  assign redir_pc_eff     = {ifu_i_redir_pc[31:2], 2'b00};
  assign redir_lsb_unused = ^ifu_i_redir_pc[1:0];
  assign fetch_halt       = 1'b0;
`endif

  // Head of the buffer drives the execute stage; everything reads zero
  // while reset is asserted or the buffer is empty.
  assign ifu_o_valid = !rst && (count_q != 2'd0);
  assign ifu_o_instr = ifu_o_valid ? ent_instr_q[rd_ptr_q] : 32'h0;
  assign ifu_o_pc    = ifu_o_valid ? ent_pc_q[rd_ptr_q]    : 32'h0;

`ifdef XF100_IFU_MISALIGN_CHK_EN
  assign ifu_o_misalign = misalign_q && !rst;
`endif

  // A word returns exactly one cycle after each strobe, so the in-flight
  // bit doubles as the push enable for the returning data.
  assign push = inflight_q;
  assign pop  = ifu_o_valid && ifu_i_ready;

  // Slot accounting: buffered words plus the word already in flight must
  // leave room for the new request. A head being popped this cycle frees
  // its slot in time, which is what lets fetch sustain one instruction per
  // cycle with only two entries.
  assign demand = {1'b0, count_q} + {2'b00, inflight_q};
  assign room   = 3'd2 + {2'b00, pop};

  assign ifu_o_ram_cs   = !rst && !ifu_i_redir_en && !fetch_halt && (demand < room);
  assign ifu_o_ram_addr = fetch_pc_q[IRAM_AW+1:2];

  // Next-state logic: issue, push of the returning word, pop on transfer,
  // and finally a redirect which overrides the buffer and fetch state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    ent_pc_d      = ent_pc_q;
    ent_instr_d   = ent_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
`ifdef XF100_IFU_MISALIGN_CHK_EN
    misalign_d    = misalign_q;
`endif

    if (ifu_o_ram_cs) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end

    if (push) begin
      ent_pc_d[wr_ptr_q]    = inflight_pc_q;
      ent_instr_d[wr_ptr_q] = ifu_i_ram_rdat;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};

    // The transfer above (if any) has already been counted by the consumer;
    // everything else buffered or returning is stale and is dropped here.
    if (ifu_i_redir_en) begin
      fetch_pc_d = redir_pc_eff;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
`ifdef XF100_IFU_MISALIGN_CHK_EN
      misalign_d = redir_bad;
`endif
    end
  end

  // State registers with synchronous reset. Clearing in-flight on reset
  // guarantees the RAM return in the cycle after reset is never pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= 32'h0;
      ent_pc_q[0]    <= 32'h0;
      ent_pc_q[1]    <= 32'h0;
      ent_instr_q[0] <= 32'h0;
      ent_instr_q[1] <= 32'h0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
`ifdef XF100_IFU_MISALIGN_CHK_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      ent_pc_q[0]    <= ent_pc_d[0];
      ent_pc_q[1]    <= ent_pc_d[1];
      ent_instr_q[0] <= ent_instr_d[0];
      ent_instr_q[1] <= ent_instr_d[1];
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
`ifdef XF100_IFU_MISALIGN_CHK_EN
      misalign_q     <= misalign_d;
`endif
    end
  end

endmodule
